// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the iterative RV32M multiply/divide unit.
interface muldiv_if #(parameter int unsigned XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, op_a, op_b, flush,
                  input  busy, done, result);
  modport slave  (input  start, funct3, op_a, op_b, flush,
                  output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply (shift-add) / restoring divide, one bit per cycle over XLEN cycles.
// Optional MULDIV_ZERO_SKIP_EN: multiply with a zero operand completes via the fast path.
module muldiv_unit #(parameter int unsigned XLEN = 32) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);
  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t state, state_nx;

  logic [CW-1:0]   cnt;
  logic [2:0]      op;
  logic            sa, sb;
  logic [XLEN-1:0] mag, acc_hi, acc_lo, result_q;

  logic            in_div, in_sa, in_sb, fast, accept;
  logic [XLEN-1:0] abs_a, abs_b, fast_val;

  logic [XLEN:0]     msum, rshift, rdiff;
  logic [XLEN-1:0]   hi_nx, lo_nx, quo, rem, fin_val;
  logic [2*XLEN-1:0] prod;

  // Entry decode: signedness, magnitudes and fast-path detection
  always_comb begin
    in_div   = bus.funct3[2];
    in_sa    = 1'b0;
    in_sb    = 1'b0;
    fast     = 1'b0;
    fast_val = '0;
    case (bus.funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        in_sa = bus.op_a[XLEN-1];
        in_sb = bus.op_b[XLEN-1];
      end
      3'b010:  in_sa = bus.op_a[XLEN-1];
      default: ;
    endcase
    abs_a = in_sa ? -bus.op_a : bus.op_a;
    abs_b = in_sb ? -bus.op_b : bus.op_b;
    if (in_div && bus.op_b == '0) begin
      fast     = 1'b1;
      fast_val = bus.funct3[1] ? bus.op_a : '1;
    end else if (in_div && !bus.funct3[0] && bus.op_b == '1 &&
                 bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) begin
      fast     = 1'b1;
      fast_val = bus.funct3[1] ? '0 : bus.op_a;
    end
`ifdef MULDIV_ZERO_SKIP_EN
    if (!in_div && (bus.op_a == '0 || bus.op_b == '0)) begin
      fast     = 1'b1;
      fast_val = '0;
    end
`else
`endif
    accept = (state == IDLE) && bus.start && !bus.flush;
  end

  // One iteration step; hi/lo hold product halves or remainder/quotient
  always_comb begin
    msum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag} : '0);
    rshift = {acc_hi, acc_lo[XLEN-1]};
    rdiff  = rshift - {1'b0, mag};
    if (op[2]) begin
      if (!rdiff[XLEN]) begin
        hi_nx = rdiff[XLEN-1:0];
        lo_nx = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nx = rshift[XLEN-1:0];
        lo_nx = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      {hi_nx, lo_nx} = {msum, acc_lo[XLEN-1:1]};
    end
    // Sign fix-up is applied to the final step so result is already registered during FIN
    prod = {hi_nx, lo_nx};
    if (sa ^ sb) prod = -prod;
    quo = (sa ^ sb) ? -lo_nx : lo_nx;
    rem = sa ? -hi_nx : hi_nx;
    if (op[2])
      fin_val = op[1] ? rem : quo;
    else
      fin_val = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_nx = fast ? FIN : CALC;
        CALC:    if (cnt == '0) state_nx = FIN;
        FIN:     state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == FIN);
  end

  assign bus.result = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      op       <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      mag      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      result_q <= '0;
    end else if (accept) begin
      op     <= bus.funct3;
      sa     <= in_sa;
      sb     <= in_sb;
      cnt    <= CW'(XLEN - 1);
      mag    <= in_div ? abs_b : abs_a;
      acc_hi <= '0;
      acc_lo <= in_div ? abs_a : abs_b;
      if (fast) result_q <= fast_val;
    end else if (state == CALC && !bus.flush) begin
      acc_hi <= hi_nx;
      acc_lo <= lo_nx;
      cnt    <= cnt - CW'(1);
      if (cnt == '0) result_q <= fin_val;
    end
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide engine and its sequencing controller. It sits beside the single-cycle ALU in the execute stage and accepts one M-extension operation at a time, selected by funct3. It runs a shift-add multiply or restoring divide over XLEN cycles and raises `busy`, which the hazard logic uses to stall the pipeline until `done`. Signed operands are handled by magnitude conversion on entry and sign fix-up on exit.

## Interface
- `XLEN`, 32, operand/result width; iteration count equals XLEN.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: operation request; sampled only in IDLE.
- `funct3` in 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a` in XLEN: rs1 value, dividend or multiplicand.
- `op_b` in XLEN: rs2 value, divisor or multiplier.
- `flush` in 1: abort any in-flight operation.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out XLEN: registered result; holds its value until the next completion.

## Operation
- States and transitions:
  - IDLE: on `start & ~flush`, latch `funct3`, operand magnitudes and the sign flags, then go to CALC. Go to FIN directly if a fast path applies.
  - CALC: runs exactly XLEN cycles on a down-counter (XLEN-1 to 0), then goes to FIN.
  - FIN: perform the sign fix-up, write `result`, assert `done`, then go to IDLE.
- Operand signedness:
  - Signed: MUL/MULH/DIV/REM treat both operands as signed.
  - Mixed: MULHSU treats `op_a` as signed and `op_b` as unsigned.
  - Unsigned: MULHU/DIVU/REMU treat both operands as unsigned.
- Multiply: 2·XLEN-bit product accumulated by shift-add of magnitudes. Negate the product if the operand signs differ. MUL returns `product[XLEN-1:0]`; the MULH variants return `product[2XLEN-1:XLEN]`.
- Divide: restoring algorithm, one quotient bit per CALC cycle. The quotient is negated if the signs differ. The remainder takes the sign of the dividend.
- Fast paths, IDLE to FIN with no CALC cycles:
  - Divisor zero: quotient = all ones; remainder = `op_a`.
  - Signed overflow (DIV/REM, `op_a` = 0x80000000, `op_b` = 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- `start` is ignored in CALC and FIN. The requester deasserts `start` in the cycle after `done`.
- `flush`: from any state, go to IDLE on the next edge. No `done` is produced and `result` is unchanged. When `flush` and `start` are high together in IDLE, `flush` wins and the operation is not accepted.
- Reset: asserting `rst_n` low forces IDLE immediately; `busy` = 0, `done` = 0, `result` = 0, counter = 0.

## Timing
- Edge E0 is the edge at which `start` is accepted in IDLE.
- Normal path: `busy` is high from E0 through the FIN cycle. `done` is high in the cycle after edge E0+XLEN, which is the (XLEN+1)th cycle after acceptance: cycle 33 for XLEN = 32.
- Fast path: `done` is high in the cycle immediately after E0.
- `busy` and `done` are decoded from the state register and carry no combinational path from the inputs. `result` is registered.
- After `done`, `busy` is low on the next edge. A back-to-back operation can therefore be accepted 1 cycle after `done`.

## Configuration
- `MULDIV_ZERO_SKIP_EN`
  - Defined: a multiply-family op with `op_a` == 0 or `op_b` == 0 takes the fast path and returns 0, with `done` in the cycle after E0.
  - Undefined: zero operands take the full XLEN-cycle CALC path. The result is identical; only the latency differs.
  - Divide fast paths are unaffected by this macro.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3) -> `result` 0xFFFFFFEB; `done` in cycle 33 after E0; `busy` high for exactly 33 cycles.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- Divides:
  - DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD.
  - REM with the same operands -> 0xFFFFFFFF.
  - DIVU 100 / 7 -> 14.
  - REMU 100 / 7 -> 2.
- Divide fast paths:
  - DIV 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, with `done` 1 cycle after E0.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
- Abort and ignored requests:
  - `flush` in CALC cycle 10 of a DIVU -> `busy` low on the next edge, no `done`, `result` retains its prior value.
  - A second `start` with new operands while `busy` -> ignored; the original result is delivered unchanged.
- Reset and zero skip:
  - `rst_n` low mid-CALC -> `busy`/`done`/`result` = 0 immediately, without a clock edge.
  - MUL 0 × 0x1234 -> 0: in the cycle after E0 with `MULDIV_ZERO_SKIP_EN` defined, in cycle 33 without it.
